instruction_fetch_stage: RTL and testbench

- PC register and IF/ID pipeline register for the MIPS core.
- Drives the combinational instruction memory: the word address is byte address bits 31:2.
- Registers the returned instruction and PC+4 toward decode.
- Handles stall, flush and branch/jump redirect.
- Enters a halted state on an out-of-range fetch.

---
 rtl/instruction_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Drives a combinational instruction memory, applies stall/flush/redirect,
// and parks in HALT after a fetch beyond the instruction memory.
// Optional build macro: FETCH_PERF_COUNTERS_EN adds fetch/stall counters.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [25:0] jump_index,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic        range_err
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_halted;
  logic        r_misalign;
  logic        r_range;

  logic        w_redirect;
  logic [31:0] w_jump_target;
  logic [31:0] w_raw_target;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic [31:0] w_pc_plus4;
  logic        w_out_of_range;

  // The jump is resolved in ID, so its upper bits come from the registered PC+4.
  assign w_redirect     = branch_taken | jump_en;
  assign w_jump_target  = {r_pc4[31:28], jump_index, 2'b00};
  assign w_raw_target   = branch_taken ? branch_target : w_jump_target;
  assign w_target       = {w_raw_target[31:2], 2'b00};
  assign w_misaligned   = w_redirect && (w_raw_target[1:0] != 2'b00);
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_out_of_range = ({2'b00, r_pc[31:2]} >= IMEM_WORDS);

  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign if_id_instr    = r_instr;
  assign if_id_pc_plus4 = r_pc4;
  assign if_id_valid    = r_valid;
  assign halted         = r_halted;
  assign misalign_err   = r_misalign;
  assign range_err      = r_range;

  // PC, IF/ID and RUN/HALT control. Bubbles clear instr/valid but leave the
  // stale PC+4 in place, since nothing downstream uses it while valid is 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_WORD;
      r_pc4      <= 32'h0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_range    <= 1'b0;
    end else begin
      if (w_misaligned) begin
        r_misalign <= 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
          end else if (stall) begin
            r_pc    <= r_pc;
          end else if (w_out_of_range) begin
            r_instr  <= NOP_WORD;
            r_valid  <= 1'b0;
            r_range  <= 1'b1;
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end else if (flush) begin
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
            r_pc    <= w_pc_plus4;
          end else begin
            r_instr <= imem_instr;
            r_pc4   <= w_pc_plus4;
            r_valid <= 1'b1;
            r_pc    <= w_pc_plus4;
          end
        end
        ST_HALT: begin
          r_instr <= NOP_WORD;
          r_valid <= 1'b0;
          if (w_redirect) begin
            r_pc     <= w_target;
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_fetch_evt;
  logic        w_stall_evt;

  assign w_fetch_evt = (r_state == ST_RUN) && !w_redirect && !stall && !w_out_of_range && !flush;
  assign w_stall_evt = (r_state == ST_RUN) && !w_redirect && stall;
  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

  // Saturating event counters for fetched instructions and stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_count <= 32'h0;
      r_stall_count <= 32'h0;
    end else begin
      if (w_fetch_evt && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall_evt && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: a vector table for the main
// fetch/stall/redirect/halt flow plus short reset and high-address jump
// sequences on a second instance with a full-range instruction memory.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr;
  logic        stall, flush, branch_taken, jump_en;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4;
  logic        if_id_valid, halted, misalign_err, range_err;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count, b_fetch_count, b_stall_count;
`endif

  // Second instance: every address in range, used for the high-bit jump.
  logic        b_reset, b_branch, b_jump, b_zero;
  logic [31:0] b_target, b_imem_addr, b_imem_instr;
  logic [25:0] b_idx;
  logic [31:0] b_pc, b_instr, b_pc4;
  logic        b_valid, b_halted, b_mis, b_rng;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h2009_0003;
    return 32'hA000_0000 | a;
  endfunction

  assign imem_instr   = imem_f(imem_addr);
  assign b_imem_instr = imem_f(b_imem_addr);

  instruction_fetch_stage dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump_en(jump_en), .jump_index(jump_index),
    .pc(pc), .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid), .halted(halted), .misalign_err(misalign_err),
    .range_err(range_err)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  instruction_fetch_stage #(.IMEM_WORDS(32'h4000_0000)) dut_big (
    .clk(clk), .reset(b_reset), .imem_addr(b_imem_addr), .imem_instr(b_imem_instr),
    .stall(b_zero), .flush(b_zero), .branch_taken(b_branch),
    .branch_target(b_target), .jump_en(b_jump), .jump_index(b_idx),
    .pc(b_pc), .if_id_instr(b_instr), .if_id_pc_plus4(b_pc4),
    .if_id_valid(b_valid), .halted(b_halted), .misalign_err(b_mis),
    .range_err(b_rng)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(b_fetch_count), .stall_count(b_stall_count)
`endif
  );

  typedef struct {
    logic [2:0]  sfb;    // {stall, flush, branch_taken}
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] idx;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [4:0]  flags;  // {valid, halted, misalign, range, compare pc4}
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [2:0] sfb, input logic [31:0] tgt,
                              input logic jmp, input logic [25:0] idx,
                              input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic [4:0] flags);
    vec_t v;
    v.sfb = sfb; v.tgt = tgt; v.jmp = jmp; v.idx = idx;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_pc4 = e_pc4; v.flags = flags;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump_en = 1'b0;
    branch_target = 32'h0; jump_index = 26'h0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " pc"}, pc, 32'h0);
    chk({tag, " instr"}, if_id_instr, 32'h0);
    chk({tag, " pc4"}, if_id_pc_plus4, 32'h0);
    chk({tag, " valid"}, {31'h0, if_id_valid}, 32'h0);
    chk({tag, " halted"}, {31'h0, halted}, 32'h0);
    chk({tag, " misalign"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, " range"}, {31'h0, range_err}, 32'h0);
  endtask

  initial begin
    // sfb       tgt         jmp  idx           pc            instr          pc4           vhmrc
    vecs[0]  = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h4,   32'h2008_0005, 32'h4,   5'b10001);
    vecs[1]  = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h8,   32'h2009_0003, 32'h8,   5'b10001);
    vecs[2]  = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'hC,   32'hA000_0008, 32'hC,   5'b10001);
    vecs[3]  = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h10,  32'hA000_000C, 32'h10,  5'b10001);
    vecs[4]  = mk(3'b100, 32'h0,   1'b0, 26'h0,       32'h10,  32'hA000_000C, 32'h10,  5'b10001);
    vecs[5]  = mk(3'b100, 32'h0,   1'b0, 26'h0,       32'h10,  32'hA000_000C, 32'h10,  5'b10001);
    vecs[6]  = mk(3'b100, 32'h0,   1'b0, 26'h0,       32'h10,  32'hA000_000C, 32'h10,  5'b10001);
    vecs[7]  = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h14,  32'hA000_0010, 32'h14,  5'b10001);
    vecs[8]  = mk(3'b101, 32'h40,  1'b1, 26'h3FFFFFF, 32'h40,  32'h0,         32'h0,   5'b00000);
    vecs[9]  = mk(3'b010, 32'h0,   1'b0, 26'h0,       32'h44,  32'h0,         32'h0,   5'b00000);
    vecs[10] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h48,  32'hA000_0044, 32'h48,  5'b10001);
    vecs[11] = mk(3'b001, 32'h42,  1'b0, 26'h0,       32'h40,  32'h0,         32'h0,   5'b00100);
    vecs[12] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h44,  32'hA000_0040, 32'h44,  5'b10101);
    vecs[13] = mk(3'b000, 32'h0,   1'b1, 26'h80,      32'h200, 32'h0,         32'h0,   5'b00100);
    vecs[14] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h200, 32'h0,         32'h0,   5'b01110);
    vecs[15] = mk(3'b110, 32'h0,   1'b0, 26'h0,       32'h200, 32'h0,         32'h0,   5'b01110);
    vecs[16] = mk(3'b001, 32'h0,   1'b0, 26'h0,       32'h0,   32'h0,         32'h0,   5'b00110);
    vecs[17] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h4,   32'h2008_0005, 32'h4,   5'b10111);
    vecs[18] = mk(3'b001, 32'h1FC, 1'b0, 26'h0,       32'h1FC, 32'h0,         32'h0,   5'b00110);
    vecs[19] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h200, 32'hA000_01FC, 32'h200, 5'b10111);
    vecs[20] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h200, 32'h0,         32'h0,   5'b01110);
    vecs[21] = mk(3'b001, 32'h300, 1'b0, 26'h0,       32'h300, 32'h0,         32'h0,   5'b00110);
    vecs[22] = mk(3'b000, 32'h0,   1'b0, 26'h0,       32'h300, 32'h0,         32'h0,   5'b01110);

    idle_inputs();
    reset = 1'b1;
    b_reset = 1'b1; b_branch = 1'b0; b_jump = 1'b0; b_zero = 1'b0;
    b_target = 32'h0; b_idx = 26'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    $display("reset: pc=%h instr=%h valid=%b", pc, if_id_instr, if_id_valid);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].sfb[2]; flush = vecs[i].sfb[1]; branch_taken = vecs[i].sfb[0];
      branch_target = vecs[i].tgt; jump_en = vecs[i].jmp; jump_index = vecs[i].idx;
      @(negedge clk);
      $display("vec %0d: pc=%h instr=%h pc4=%h v=%b h=%b m=%b r=%b", i, pc,
               if_id_instr, if_id_pc_plus4, if_id_valid, halted, misalign_err, range_err);
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d instr", i), if_id_instr, vecs[i].e_instr);
      if (vecs[i].flags[0]) chk($sformatf("v%0d pc4", i), if_id_pc_plus4, vecs[i].e_pc4);
      chk($sformatf("v%0d flags", i), {28'h0, if_id_valid, halted, misalign_err, range_err},
          {28'h0, vecs[i].flags[4:1]});
`ifdef FETCH_PERF_COUNTERS_EN
      if (i == 6) begin
        chk("stall_count", stall_count, 32'd3);
        chk("fetch_count", fetch_count, 32'd4);
      end
`endif
    end

    // Reset while halted with both sticky errors set.
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_in_halt");
    $display("reset_in_halt: pc=%h halted=%b range=%b", pc, halted, range_err);

    // One fetch, then reset asserted together with stall.
    reset = 1'b0;
    @(negedge clk);
    chk("pre_stall pc", pc, 32'h4);
    stall = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk_reset_state("reset_in_stall");
    $display("reset_in_stall: pc=%h valid=%b", pc, if_id_valid);
    reset = 1'b0; stall = 1'b0;

    // High-address jump: fetch at 0x1000_0004 so PC+4 carries 0x1 in bits 31:28.
    @(negedge clk);
    b_reset = 1'b0; b_branch = 1'b1; b_target = 32'h1000_0004;
    @(negedge clk);
    chk("big branch pc", b_pc, 32'h1000_0004);
    b_branch = 1'b0;
    @(negedge clk);
    chk("big pc4", b_pc4, 32'h1000_0008);
    chk("big instr", b_instr, 32'hB000_0004);
    b_jump = 1'b1; b_idx = 26'h0000010;
    @(negedge clk);
    chk("big jump pc", b_pc, 32'h1000_0040);
    chk("big jump valid", {31'h0, b_valid}, 32'h0);
    $display("big_jump: pc=%h pc4=%h", b_pc, b_pc4);
    b_jump = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
